// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the ELEC-326 multi-cycle control sequencer:
// state encodings plus the PC-source and write-back select codes.
package cpu_ctrl_pkg;

    localparam int unsigned STATE_W  = 3;
    localparam int unsigned PC_SRC_W = 2;
    localparam int unsigned WB_SEL_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET     = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEM       = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALTED    = 3'd6
    } state_t;

    // PC next-value source
    localparam logic [PC_SRC_W-1:0] PC_SRC_INC    = 2'b00;
    localparam logic [PC_SRC_W-1:0] PC_SRC_OFFSET = 2'b01;
    localparam logic [PC_SRC_W-1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [PC_SRC_W-1:0] PC_SRC_ZERO   = 2'b11;

    // Register-file write-back source
    localparam logic [WB_SEL_W-1:0] WB_SEL_ALU = 2'b00;
    localparam logic [WB_SEL_W-1:0] WB_SEL_MDR = 2'b01;
    localparam logic [WB_SEL_W-1:0] WB_SEL_IMM = 2'b10;

endpackage

// File: rtl/cpu_branch_eval.sv
// Combinational branch-taken decision.
// Ports:
//   branch_eq/ge/le/carry : decoder branch class flags
//   cmp_eq/gt/lt          : datapath compare of source_reg1 vs source_reg2
//   carry_flag            : current carry flag
//   taken_c               : branch should redirect the PC
module cpu_branch_eval (
    input  logic branch_eq,
    input  logic branch_ge,
    input  logic branch_le,
    input  logic branch_carry,
    input  logic cmp_eq,
    input  logic cmp_gt,
    input  logic cmp_lt,
    input  logic carry_flag,
    output logic taken_c
);

    assign taken_c = (branch_eq    & cmp_eq)
                   | (branch_ge    & (cmp_gt | cmp_eq))
                   | (branch_le    & (cmp_lt | cmp_eq))
                   | (branch_carry & carry_flag);

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control sequencer for the 16-bit ELEC-326 datapath.
// Sequences FETCH -> DECODE -> EXECUTE [-> MEM] [-> WRITEBACK] and drives the
// PC, IR, register-file, memory-request and carry-flag strobes. Strobes are
// combinational from the registered state and current inputs, and are forced
// low while reset_pi is high.
// Ports:
//   clk_pi, reset_pi        : clock, async active-high reset
//   *_pi class flags        : one-hot decoder classes and control commands
//   cmp_*_pi, carry_flag_pi : branch condition inputs
//   mem_ready_pi            : memory handshake
//   resume_pi               : leave HALTED
//   mem_req/we, ir_write, mdr_write, pc_write, pc_src, reg_write, wb_sel,
//   carry_set, borrow_set, soft_rst, retire, halted, state : control outputs
// Optional build macro CPU_CTRL_RETIRE_COUNT_EN adds retired_count_po.
module cpu_control_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                clk_pi,
    input  logic                reset_pi,
    input  logic                arith_2op_pi,
    input  logic                arith_1op_pi,
    input  logic                movi_lower_pi,
    input  logic                movi_higher_pi,
    input  logic                addi_pi,
    input  logic                subi_pi,
    input  logic                load_pi,
    input  logic                store_pi,
    input  logic                branch_eq_pi,
    input  logic                branch_ge_pi,
    input  logic                branch_le_pi,
    input  logic                branch_carry_pi,
    input  logic                jump_pi,
    input  logic                stc_cmd_pi,
    input  logic                stb_cmd_pi,
    input  logic                halt_cmd_pi,
    input  logic                rst_cmd_pi,
    input  logic                cmp_eq_pi,
    input  logic                cmp_gt_pi,
    input  logic                cmp_lt_pi,
    input  logic                carry_flag_pi,
    input  logic                mem_ready_pi,
    input  logic                resume_pi,
    output logic                mem_req_po,
    output logic                mem_we_po,
    output logic                ir_write_po,
    output logic                mdr_write_po,
    output logic                pc_write_po,
    output logic [PC_SRC_W-1:0] pc_src_po,
    output logic                reg_write_po,
    output logic [WB_SEL_W-1:0] wb_sel_po,
    output logic                carry_set_po,
    output logic                borrow_set_po,
    output logic                soft_rst_po,
    output logic                retire_po,
    output logic                halted_po,
    output logic [STATE_W-1:0]  state_po
`ifdef CPU_CTRL_RETIRE_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0] retired_count_po
`endif
);

    if (CNT_WIDTH < 1) begin : g_cnt_width_check
        $error("CNT_WIDTH must be at least 1");
    end

    state_t state_q;
    state_t state_d;
    logic   branch_taken_c;
    logic   is_branch_c;
    logic   is_alu_c;
    logic   is_movi_c;

    cpu_branch_eval u_branch_eval (
        .branch_eq    (branch_eq_pi),
        .branch_ge    (branch_ge_pi),
        .branch_le    (branch_le_pi),
        .branch_carry (branch_carry_pi),
        .cmp_eq       (cmp_eq_pi),
        .cmp_gt       (cmp_gt_pi),
        .cmp_lt       (cmp_lt_pi),
        .carry_flag   (carry_flag_pi),
        .taken_c      (branch_taken_c)
    );

    assign is_branch_c = branch_eq_pi | branch_ge_pi | branch_le_pi | branch_carry_pi;
    assign is_movi_c   = movi_lower_pi | movi_higher_pi;
    assign is_alu_c    = arith_2op_pi | arith_1op_pi | addi_pi | subi_pi | is_movi_c;

    // State register
    always_ff @(posedge clk_pi or posedge reset_pi) begin
        if (reset_pi) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and strobe decode
    always_comb begin
        state_d       = state_q;
        mem_req_po    = 1'b0;
        mem_we_po     = 1'b0;
        ir_write_po   = 1'b0;
        mdr_write_po  = 1'b0;
        pc_write_po   = 1'b0;
        pc_src_po     = PC_SRC_INC;
        reg_write_po  = 1'b0;
        wb_sel_po     = WB_SEL_ALU;
        carry_set_po  = 1'b0;
        borrow_set_po = 1'b0;
        soft_rst_po   = 1'b0;
        retire_po     = 1'b0;
        halted_po     = 1'b0;

        case (state_q)
            ST_RESET: begin
                pc_write_po = 1'b1;
                pc_src_po   = PC_SRC_ZERO;
                state_d     = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req_po = 1'b1;
                if (mem_ready_pi) begin
                    ir_write_po = 1'b1;
                    pc_write_po = 1'b1;
                    state_d     = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                // Fixed priority; decoder flags are one-hot in normal operation
                if (rst_cmd_pi) begin
                    soft_rst_po = 1'b1;
                    retire_po   = 1'b1;
                    state_d     = ST_RESET;
                end else if (halt_cmd_pi) begin
                    retire_po = 1'b1;
                    state_d   = ST_HALTED;
                end else if (load_pi || store_pi) begin
                    state_d = ST_MEM;
                end else if (jump_pi) begin
                    pc_write_po = 1'b1;
                    pc_src_po   = PC_SRC_JUMP;
                    retire_po   = 1'b1;
                    state_d     = ST_FETCH;
                end else if (is_branch_c) begin
                    if (branch_taken_c) begin
                        pc_write_po = 1'b1;
                        pc_src_po   = PC_SRC_OFFSET;
                    end
                    retire_po = 1'b1;
                    state_d   = ST_FETCH;
                end else if (is_alu_c) begin
                    state_d = ST_WRITEBACK;
                end else begin
                    // STC/STB pulse their strobe; NOP and undefined just retire
                    carry_set_po  = stc_cmd_pi;
                    borrow_set_po = stb_cmd_pi;
                    retire_po     = 1'b1;
                    state_d       = ST_FETCH;
                end
            end
            ST_MEM: begin
                mem_req_po = 1'b1;
                mem_we_po  = store_pi;
                if (mem_ready_pi) begin
                    if (load_pi) begin
                        mdr_write_po = 1'b1;
                        state_d      = ST_WRITEBACK;
                    end else begin
                        retire_po = 1'b1;
                        state_d   = ST_FETCH;
                    end
                end
            end
            ST_WRITEBACK: begin
                reg_write_po = 1'b1;
                retire_po    = 1'b1;
                if (is_movi_c) begin
                    wb_sel_po = WB_SEL_IMM;
                end else if (load_pi) begin
                    wb_sel_po = WB_SEL_MDR;
                end
                state_d = ST_FETCH;
            end
            ST_HALTED: begin
                halted_po = 1'b1;
                if (resume_pi) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase

        // Reset silences every strobe at once, including an in-flight mem_req
        if (reset_pi) begin
            mem_req_po    = 1'b0;
            mem_we_po     = 1'b0;
            ir_write_po   = 1'b0;
            mdr_write_po  = 1'b0;
            pc_write_po   = 1'b0;
            pc_src_po     = PC_SRC_INC;
            reg_write_po  = 1'b0;
            wb_sel_po     = WB_SEL_ALU;
            carry_set_po  = 1'b0;
            borrow_set_po = 1'b0;
            soft_rst_po   = 1'b0;
            retire_po     = 1'b0;
            halted_po     = 1'b0;
        end
    end

    assign state_po = state_q;

`ifdef CPU_CTRL_RETIRE_COUNT_EN
    logic [CNT_WIDTH-1:0] retired_count_q;

    // Retired-instruction counter; the soft-reset instruction clears rather than counts
    always_ff @(posedge clk_pi or posedge reset_pi) begin
        if (reset_pi) begin
            retired_count_q <= '0;
        end else if (soft_rst_po) begin
            retired_count_q <= '0;
        end else if (retire_po) begin
            retired_count_q <= retired_count_q + CNT_WIDTH'(1);
        end
    end

    assign retired_count_po = retired_count_q;
`endif

endmodule

// File: tb/tb_cpu_control_fsm.sv
module tb_cpu_control_fsm;

    logic clk_pi = 1'b0;
    logic reset_pi;
    logic arith_2op_pi, arith_1op_pi, movi_lower_pi, movi_higher_pi, addi_pi, subi_pi;
    logic load_pi, store_pi, branch_eq_pi, branch_ge_pi, branch_le_pi, branch_carry_pi, jump_pi;
    logic stc_cmd_pi, stb_cmd_pi, halt_cmd_pi, rst_cmd_pi;
    logic cmp_eq_pi, cmp_gt_pi, cmp_lt_pi, carry_flag_pi;
    logic mem_ready_pi, resume_pi;

    logic       mem_req_po, mem_we_po, ir_write_po, mdr_write_po, pc_write_po;
    logic [1:0] pc_src_po;
    logic       reg_write_po;
    logic [1:0] wb_sel_po;
    logic       carry_set_po, borrow_set_po, soft_rst_po, retire_po, halted_po;
    logic [2:0] state_po;
`ifdef CPU_CTRL_RETIRE_COUNT_EN
    logic [15:0] retired_count_po;
`endif

    cpu_control_fsm #(.CNT_WIDTH(16)) dut (
        .clk_pi          (clk_pi),
        .reset_pi        (reset_pi),
        .arith_2op_pi    (arith_2op_pi),
        .arith_1op_pi    (arith_1op_pi),
        .movi_lower_pi   (movi_lower_pi),
        .movi_higher_pi  (movi_higher_pi),
        .addi_pi         (addi_pi),
        .subi_pi         (subi_pi),
        .load_pi         (load_pi),
        .store_pi        (store_pi),
        .branch_eq_pi    (branch_eq_pi),
        .branch_ge_pi    (branch_ge_pi),
        .branch_le_pi    (branch_le_pi),
        .branch_carry_pi (branch_carry_pi),
        .jump_pi         (jump_pi),
        .stc_cmd_pi      (stc_cmd_pi),
        .stb_cmd_pi      (stb_cmd_pi),
        .halt_cmd_pi     (halt_cmd_pi),
        .rst_cmd_pi      (rst_cmd_pi),
        .cmp_eq_pi       (cmp_eq_pi),
        .cmp_gt_pi       (cmp_gt_pi),
        .cmp_lt_pi       (cmp_lt_pi),
        .carry_flag_pi   (carry_flag_pi),
        .mem_ready_pi    (mem_ready_pi),
        .resume_pi       (resume_pi),
        .mem_req_po      (mem_req_po),
        .mem_we_po       (mem_we_po),
        .ir_write_po     (ir_write_po),
        .mdr_write_po    (mdr_write_po),
        .pc_write_po     (pc_write_po),
        .pc_src_po       (pc_src_po),
        .reg_write_po    (reg_write_po),
        .wb_sel_po       (wb_sel_po),
        .carry_set_po    (carry_set_po),
        .borrow_set_po   (borrow_set_po),
        .soft_rst_po     (soft_rst_po),
        .retire_po       (retire_po),
        .halted_po       (halted_po),
        .state_po        (state_po)
`ifdef CPU_CTRL_RETIRE_COUNT_EN
        ,
        .retired_count_po(retired_count_po)
`endif
    );

    always #5 clk_pi = ~clk_pi;

    // Observed output vector, field order matches obs_t
    typedef struct packed {
        logic [2:0] state;
        logic       mem_req;
        logic       mem_we;
        logic       ir_write;
        logic       mdr_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       carry_set;
        logic       borrow_set;
        logic       soft_rst;
        logic       retire;
        logic       halted;
    } obs_t;

    typedef struct {
        string       tag;
        obs_t        o;
        logic [15:0] cnt;
    } sb_t;

    obs_t        obs;
    sb_t         sb_q[$];
    sb_t         mon_s;
    logic [15:0] exp_cnt = '0;
    int          n_total = 0;
    int          n_bad   = 0;
    logic [8:0]  br_tab [8];

    assign obs = {state_po, mem_req_po, mem_we_po, ir_write_po, mdr_write_po, pc_write_po,
                  pc_src_po, reg_write_po, wb_sel_po, carry_set_po, borrow_set_po,
                  soft_rst_po, retire_po, halted_po};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic obs_t mk(input logic [2:0] st);
        obs_t o = '0;
        o.state = st;
        return o;
    endfunction

    function automatic obs_t x_zero();
        return mk(3'd0);
    endfunction

    function automatic obs_t x_reset();
        obs_t o = mk(3'd0);
        o.pc_write = 1'b1;
        o.pc_src   = 2'b11;
        return o;
    endfunction

    function automatic obs_t x_fetch(input logic rdy);
        obs_t o = mk(3'd1);
        o.mem_req = 1'b1;
        if (rdy) begin
            o.ir_write = 1'b1;
            o.pc_write = 1'b1;
        end
        return o;
    endfunction

    function automatic obs_t x_decode();
        return mk(3'd2);
    endfunction

    function automatic obs_t x_exec_go();
        return mk(3'd3);
    endfunction

    function automatic obs_t x_exec_ret(input logic pcw, input logic [1:0] src);
        obs_t o = mk(3'd3);
        o.retire   = 1'b1;
        o.pc_write = pcw;
        o.pc_src   = src;
        return o;
    endfunction

    function automatic obs_t x_mem(input logic we, input logic rdy, input logic ld);
        obs_t o = mk(3'd4);
        o.mem_req = 1'b1;
        o.mem_we  = we;
        if (rdy) begin
            if (ld) o.mdr_write = 1'b1;
            else    o.retire    = 1'b1;
        end
        return o;
    endfunction

    function automatic obs_t x_wb(input logic [1:0] sel);
        obs_t o = mk(3'd5);
        o.reg_write = 1'b1;
        o.retire    = 1'b1;
        o.wb_sel    = sel;
        return o;
    endfunction

    function automatic obs_t x_halt();
        obs_t o = mk(3'd6);
        o.halted = 1'b1;
        return o;
    endfunction

    task automatic clear_flags();
        arith_2op_pi = 0; arith_1op_pi = 0; movi_lower_pi = 0; movi_higher_pi = 0;
        addi_pi = 0; subi_pi = 0; load_pi = 0; store_pi = 0;
        branch_eq_pi = 0; branch_ge_pi = 0; branch_le_pi = 0; branch_carry_pi = 0; jump_pi = 0;
        stc_cmd_pi = 0; stb_cmd_pi = 0; halt_cmd_pi = 0; rst_cmd_pi = 0;
        cmp_eq_pi = 0; cmp_gt_pi = 0; cmp_lt_pi = 0; carry_flag_pi = 0;
    endtask

    // Drive one cycle and queue what the outputs must be during it
    task automatic cycle(input string tag, input logic rdy, input obs_t e);
        sb_t s;
        mem_ready_pi = rdy;
        s.tag = tag;
        s.o   = e;
        s.cnt = exp_cnt;
        sb_q.push_back(s);
        if (reset_pi || e.soft_rst) exp_cnt = '0;
        else if (e.retire)          exp_cnt = exp_cnt + 16'd1;
        @(posedge clk_pi);
        #1;
    endtask

    task automatic front(input string tag);
        cycle({tag, "_fetch"}, 1'b1, x_fetch(1'b1));
        cycle({tag, "_dec"},   1'b1, x_decode());
    endtask

    // Scoreboard consumer, samples mid-cycle
    always @(negedge clk_pi) begin
        if (sb_q.size() != 0) begin
            mon_s = sb_q.pop_front();
            check(mon_s.tag, 32'(obs), 32'(mon_s.o));
`ifdef CPU_CTRL_RETIRE_COUNT_EN
            check({mon_s.tag, "_cnt"}, 32'(retired_count_po), 32'(mon_s.cnt));
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o;
        // {beq, bge, ble, bc, eq, gt, lt, carry, taken}
        br_tab[0] = 9'b1000_1000_1;
        br_tab[1] = 9'b1000_0100_0;
        br_tab[2] = 9'b0001_0001_1;
        br_tab[3] = 9'b0100_0100_1;
        br_tab[4] = 9'b0100_0010_0;
        br_tab[5] = 9'b0010_1000_1;
        br_tab[6] = 9'b0010_0100_0;
        br_tab[7] = 9'b0001_1110_0;

        clear_flags();
        reset_pi = 1'b1; resume_pi = 1'b0; mem_ready_pi = 1'b0;
        @(posedge clk_pi); #1;
        cycle("rst_hold", 1'b1, x_zero());
        cycle("rst_hold2", 1'b1, x_zero());
        reset_pi = 1'b0;
        cycle("reset", 1'b1, x_reset());

        // NOP, zero-wait
        front("nop");
        cycle("nop_exec", 1'b1, x_exec_ret(1'b0, 2'b00));

        // ADD with three fetch waits
        arith_2op_pi = 1'b1;
        repeat (3) cycle("add_fwait", 1'b0, x_fetch(1'b0));
        cycle("add_fetch", 1'b1, x_fetch(1'b1));
        cycle("add_dec", 1'b1, x_decode());
        cycle("add_exec", 1'b1, x_exec_go());
        cycle("add_wb", 1'b1, x_wb(2'b00));

        // LOAD, two memory waits
        clear_flags(); load_pi = 1'b1;
        front("ld");
        cycle("ld_exec", 1'b1, x_exec_go());
        repeat (2) cycle("ld_mwait", 1'b0, x_mem(1'b0, 1'b0, 1'b1));
        cycle("ld_mem", 1'b1, x_mem(1'b0, 1'b1, 1'b1));
        cycle("ld_wb", 1'b1, x_wb(2'b01));

        // STORE, two memory waits
        clear_flags(); store_pi = 1'b1;
        front("st");
        cycle("st_exec", 1'b1, x_exec_go());
        repeat (2) cycle("st_mwait", 1'b0, x_mem(1'b1, 1'b0, 1'b0));
        cycle("st_mem", 1'b1, x_mem(1'b1, 1'b1, 1'b0));

        // Branch conditions
        for (int i = 0; i < 8; i++) begin
            clear_flags();
            {branch_eq_pi, branch_ge_pi, branch_le_pi, branch_carry_pi,
             cmp_eq_pi, cmp_gt_pi, cmp_lt_pi, carry_flag_pi} = br_tab[i][8:1];
            front($sformatf("br%0d", i));
            cycle($sformatf("br%0d_exec", i), 1'b1,
                  x_exec_ret(br_tab[i][0], br_tab[i][0] ? 2'b01 : 2'b00));
        end

        // JUMP
        clear_flags(); jump_pi = 1'b1;
        front("jmp");
        cycle("jmp_exec", 1'b1, x_exec_ret(1'b1, 2'b10));

        // MOVI upper byte uses the immediate write-back path
        clear_flags(); movi_higher_pi = 1'b1;
        front("movi");
        cycle("movi_exec", 1'b1, x_exec_go());
        cycle("movi_wb", 1'b1, x_wb(2'b10));

        // SUBI is an ALU write-back
        clear_flags(); subi_pi = 1'b1;
        front("subi");
        cycle("subi_exec", 1'b1, x_exec_go());
        cycle("subi_wb", 1'b1, x_wb(2'b00));

        // STC / STB
        clear_flags(); stc_cmd_pi = 1'b1;
        front("stc");
        o = x_exec_ret(1'b0, 2'b00); o.carry_set = 1'b1;
        cycle("stc_exec", 1'b1, o);
        clear_flags(); stb_cmd_pi = 1'b1;
        front("stb");
        o = x_exec_ret(1'b0, 2'b00); o.borrow_set = 1'b1;
        cycle("stb_exec", 1'b1, o);

        // HALT, resume after five idle cycles
        clear_flags(); halt_cmd_pi = 1'b1;
        front("halt");
        cycle("halt_exec", 1'b1, x_exec_ret(1'b0, 2'b00));
        clear_flags();
        repeat (5) cycle("halted", 1'b1, x_halt());
        resume_pi = 1'b1;
        cycle("halted_resume", 1'b1, x_halt());
        resume_pi = 1'b0;
        front("post_halt");
        cycle("post_halt_exec", 1'b1, x_exec_ret(1'b0, 2'b00));

        // Soft-reset command
        rst_cmd_pi = 1'b1;
        front("srst");
        o = x_exec_ret(1'b0, 2'b00); o.soft_rst = 1'b1;
        cycle("srst_exec", 1'b1, o);
        clear_flags();
        cycle("srst_reset", 1'b1, x_reset());
        front("nop2");
        cycle("nop2_exec", 1'b1, x_exec_ret(1'b0, 2'b00));

        // Async reset while LOAD waits in MEM
        load_pi = 1'b1;
        front("ar");
        cycle("ar_exec", 1'b1, x_exec_go());
        cycle("ar_mwait", 1'b0, x_mem(1'b0, 1'b0, 1'b1));
        mem_ready_pi = 1'b0;
        #2;
        check("ar_mreq_before", 32'(mem_req_po), 32'd1);
        reset_pi = 1'b1;
        exp_cnt  = '0;
        #1;
        check("ar_mreq_drop", 32'(mem_req_po), 32'd0);
        check("ar_state", 32'(state_po), 32'd0);
`ifdef CPU_CTRL_RETIRE_COUNT_EN
        check("ar_cnt", 32'(retired_count_po), 32'd0);
`endif
        cycle("ar_hold", 1'b1, x_zero());
        reset_pi = 1'b0;
        clear_flags();
        cycle("ar_reset", 1'b1, x_reset());
        front("nop3");
        cycle("nop3_exec", 1'b1, x_exec_ret(1'b0, 2'b00));

        @(negedge clk_pi); #1;
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_control_fsm.md
Name: cpu_control_fsm

Overview:
Multi-cycle control sequencer for the 16-bit ELEC-326 datapath. It consumes the one-hot class flags from the instruction decoder and sequences fetch, decode, execute, memory and write-back. It drives the PC, IR, register-file, memory-request and carry-flag strobes. It sits between the decoder, the shared instruction/data memory port and the datapath registers.

Parameters:
CNT_WIDTH, 16, width of the retired-instruction counter (used only with the optional feature).

Ports:
clk_pi  in  1  system clock, rising edge.
reset_pi  in  1  asynchronous, active-high reset.
arith_2op_pi, arith_1op_pi, movi_lower_pi, movi_higher_pi, addi_pi, subi_pi  in  1 each  decoder class flags.
load_pi, store_pi, branch_eq_pi, branch_ge_pi, branch_le_pi, branch_carry_pi, jump_pi  in  1 each  decoder class flags.
stc_cmd_pi, stb_cmd_pi, halt_cmd_pi, rst_cmd_pi  in  1 each  decoder control commands.
cmp_eq_pi, cmp_gt_pi, cmp_lt_pi  in  1 each  datapath compare of source_reg1 vs source_reg2.
carry_flag_pi  in  1  current carry flag.
mem_ready_pi  in  1  memory accepts or returns data this cycle.
resume_pi  in  1  leave HALTED.
mem_req_po  out  1  memory request, held until mem_ready_pi.
mem_we_po  out  1  write enable qualifying mem_req_po.
ir_write_po  out  1  load IR from memory data.
mdr_write_po  out  1  load memory-data register.
pc_write_po  out  1  update PC.
pc_src_po  out  2  00 = PC+1, 01 = PC+offset, 10 = jump target, 11 = zero.
reg_write_po  out  1  register-file write.
wb_sel_po  out  2  00 = ALU, 01 = MDR, 10 = immediate.
carry_set_po, borrow_set_po  out  1 each  one-cycle STC/STB strobes.
soft_rst_po  out  1  one-cycle datapath soft reset.
retire_po  out  1  pulses on an instruction's final cycle.
halted_po  out  1  high in HALTED.
state_po  out  3  current state encoding.

Behaviour:
- Clocking and reset: one clock, clk_pi. reset_pi is asynchronous and active-high. While reset_pi is high, state is RESET and every strobe output is 0.
- Outputs are combinational from the registered state plus the current inputs. Only the state and the counter are flopped.
- State encodings: RESET = 0, FETCH = 1, DECODE = 2, EXECUTE = 3, MEM = 4, WRITEBACK = 5, HALTED = 6.
- RESET: pc_write = 1 with pc_src = 11. Goes to FETCH on the next cycle.
- FETCH:
  - mem_req = 1, mem_we = 0.
  - Stays in FETCH while mem_ready_pi = 0.
  - On mem_ready_pi = 1: ir_write = 1, pc_write = 1, pc_src = 00, then DECODE.
- DECODE: one cycle for register read; no strobes. Goes to EXECUTE.
- EXECUTE, evaluated in this fixed priority order:
  1. rst_cmd: soft_rst = 1, retire = 1, then RESET.
  2. halt_cmd: retire = 1, then HALTED.
  3. load or store: go to MEM.
  4. jump: pc_write = 1, pc_src = 10, retire = 1, then FETCH.
  5. Branches: taken if (beq & cmp_eq) | (bge & (cmp_gt | cmp_eq)) | (ble & (cmp_lt | cmp_eq)) | (bc & carry_flag). If taken, pc_write = 1 and pc_src = 01. Always retire = 1, then FETCH.
  6. arith_2op, arith_1op, addi, subi, movi_lower or movi_higher: go to WRITEBACK.
  7. stc or stb: pulse the matching set strobe, retire = 1, then FETCH.
  8. Anything else (NOP, undefined opcode, undefined CONTROL immediate): retire = 1, then FETCH.
- MEM:
  - mem_req = 1, mem_we = store_pi. Waits until mem_ready_pi = 1.
  - Load: mdr_write = 1, then WRITEBACK.
  - Store: retire = 1, then FETCH.
- WRITEBACK: reg_write = 1 and retire = 1, then FETCH. wb_sel is 10 for movi_lower/movi_higher, 01 for load, 00 otherwise.
- HALTED: halted = 1, no strobes. resume_pi = 1 moves to FETCH on the next edge; the PC already points past HALT.
- Decoder inputs are read only in EXECUTE, MEM and WRITEBACK; the IR holds them stable there.
- mem_ready_pi is ignored when mem_req_po = 0.
- A reset asserted mid-transaction drops mem_req_po immediately; there is no completion guarantee.
- Latency (zero-wait memory): ALU instruction 4 cycles, load 5, store 4, branch/jump/NOP 3.

Optional Feature:
- Macro: CPU_CTRL_RETIRE_COUNT_EN.
- Defined: adds output retired_count_po [CNT_WIDTH-1:0]. It increments on every retire_po and wraps to 0 past all-ones. It clears on reset_pi and on soft_rst_po; the soft-reset instruction is not counted.
- Undefined: neither the port nor the counter exists.

Decomposition:
- Shared package cpu_ctrl_pkg holds the state encodings and the pc_src / wb_sel codes.
- Opcode and function `defines stay in the existing decoder defines.
- One natural sub-module: cpu_branch_eval, a combinational taken-decision from the branch flags, compare flags and carry.

Test Plan:
- Reset, then NOP with mem_ready always 1 -> RESET, FETCH, DECODE, EXECUTE, FETCH; pc_src 11 then 00; retire pulses once on cycle 4.
- ADD with mem_ready low for 3 cycles in FETCH -> mem_req held 4 cycles; ir_write only on the ready cycle; reg_write with wb_sel 00 in WRITEBACK.
- LOAD then STORE, ready after 2 waits -> load gives mdr_write then reg_write with wb_sel 01; store gives mem_we = 1 and no reg_write.
- BEQ with cmp_eq = 1 then cmp_eq = 0; BC with carry = 1 -> pc_write/pc_src 01 for the first and third only; retire on all three.
- HALT, then resume_pi held low for 5 cycles and high for 1 -> halted_po high for 6 cycles; next state FETCH.
- RESET command mid-program, and async reset_pi during MEM wait -> soft_rst pulse then RESET state; mem_req drops in the same cycle as reset_pi; with CPU_CTRL_RETIRE_COUNT_EN the counter reads 0 afterwards.
